uart_tx_mmio: RTL

Memory-mapped UART transmitter that sits as a responder on the core's data-memory bus, alongside the instruction/data memory in the minimal SoC. The core writes bytes into a small transmit FIFO through ordinary store instructions. A baud-rate state machine serializes those bytes onto a single `tx` line in 8N1 format. Status and configuration registers are readable with ordinary loads.

---
 rtl/uart_tx_mmio_pkg.sv | 29 ++
 rtl/sync_fifo.sv | 61 ++++++
 rtl/uart_tx_mmio.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/uart_tx_mmio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_mmio_pkg
// Description : Register offsets, STATUS bit positions and FSM encodings
//               shared by the memory-mapped UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_mmio_pkg;

    localparam logic [1:0] UART_TXDATA  = 2'd0;
    localparam logic [1:0] UART_STATUS  = 2'd1;
    localparam logic [1:0] UART_BAUDDIV = 2'd2;
    localparam logic [1:0] UART_CTRL    = 2'd3;

    localparam int STAT_FULL  = 0;
    localparam int STAT_EMPTY = 1;
    localparam int STAT_BUSY  = 2;
    localparam int STAT_OVF   = 3;
    localparam int STAT_CNT   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock show-ahead FIFO; push/pop ignored when full/empty.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             w_push;
    logic             w_pop;

    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;
    // DEPTH is a power of two, so the count MSB alone flags full
    assign full_o  = count_q[AW];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_mmio.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_mmio
// Description : Bus-attached 8N1 UART transmitter with TX FIFO and registers.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_mmio
    import uart_tx_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ce,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [3:0]  mem_sel,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_data_o,
    output logic        tx
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             w_sel, w_wr, w_rd, w_push_req;
    logic [1:0]       w_reg;
    logic             fifo_pop, fifo_full, fifo_empty;
    logic [7:0]       fifo_rdata;
    logic [CNT_W-1:0] fifo_count;
    logic [31:0]      status_w;
    logic             w_unused;

    logic             ovf_q, en_q, tx_q, tx_d;
    logic [15:0]      baud_div_q, baud_cnt_q, baud_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    tx_state_e        state_q, state_d;

    assign w_sel      = mem_ce && (mem_addr[31:4] == BASE_ADDR[31:4]);
    assign w_wr       = w_sel && mem_we;
    assign w_rd       = w_sel && !mem_we;
    assign w_reg      = mem_addr[3:2];
    assign w_push_req = w_wr && (w_reg == UART_TXDATA) && mem_sel[0];
    assign tx         = tx_q;
    assign w_unused   = ^{mem_addr[1:0], mem_sel[3:2], mem_data_i[31:16]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_push_req),
        .pop_i   (fifo_pop),
        .wdata_i (mem_data_i[7:0]),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q      <= 1'b0;
            baud_div_q <= DEFAULT_DIV;
            en_q       <= 1'b1;
        end else begin
            // FULL is the pre-edge value, so a same-edge pop cannot rescue the byte
            if (w_push_req && fifo_full) begin
                ovf_q <= 1'b1;
            end else if (w_wr && (w_reg == UART_STATUS) && mem_data_i[STAT_OVF]) begin
                ovf_q <= 1'b0;
            end
            if (w_wr && (w_reg == UART_BAUDDIV)) begin
                if (mem_sel[0]) baud_div_q[7:0]  <= mem_data_i[7:0];
                if (mem_sel[1]) baud_div_q[15:8] <= mem_data_i[15:8];
            end
            if (w_wr && (w_reg == UART_CTRL)) begin
                en_q <= mem_data_i[0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tx_q       <= 1'b1;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            baud_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            baud_cnt_q <= baud_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        baud_cnt_d = baud_cnt_q - 16'd1;
        tx_d       = tx_q;
        fifo_pop   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                baud_cnt_d = baud_cnt_q;
                tx_d       = 1'b1;
                if (en_q && !fifo_empty) begin
                    fifo_pop   = 1'b1;
                    state_d    = ST_START;
                    shift_d    = fifo_rdata;
                    bit_cnt_d  = 3'd0;
                    baud_cnt_d = baud_div_q;
                    tx_d       = 1'b0;
                end
            end
            ST_START: begin
                if (baud_cnt_q == 16'd0) begin
                    state_d    = ST_DATA;
                    baud_cnt_d = baud_div_q;
                    tx_d       = shift_q[0];
                end
            end
            ST_DATA: begin
                if (baud_cnt_q == 16'd0) begin
                    baud_cnt_d = baud_div_q;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        tx_d      = shift_q[1];
                    end
                end
            end
            ST_STOP: begin
                if (baud_cnt_q == 16'd0) begin
                    state_d = ST_IDLE;
                    tx_d    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        status_w                  = '0;
        status_w[STAT_FULL]       = fifo_full;
        status_w[STAT_EMPTY]      = fifo_empty;
        status_w[STAT_BUSY]       = (state_q != ST_IDLE) || !fifo_empty;
        status_w[STAT_OVF]        = ovf_q;
        status_w[STAT_CNT +: 5]   = 5'(fifo_count);
        mem_data_o                = '0;
        if (!rst && w_rd) begin
            case (w_reg)
                UART_STATUS:  mem_data_o = status_w;
                UART_BAUDDIV: mem_data_o = {16'h0, baud_div_q};
                UART_CTRL:    mem_data_o = {31'h0, en_q};
                default:      mem_data_o = '0;
            endcase
        end
    end

endmodule
`default_nettype wire
